// File: rtl/multi_lane_decode_stage.sv
// N-lane RISC-V main-decode stage with a 2-entry elastic output buffer,
// flush support and a saturating illegal-opcode counter. Optional JAL decode: DECODE_JUMP_EN.
module multi_lane_decode_stage #(
   parameter int LANES  = 2,
   parameter int CNT_W  = 16,
   parameter int CTRL_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*7-1:0]        op_in,
   input  logic [LANES-1:0]          lane_en,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*CTRL_W-1:0]   ctrl_out,
   output logic [LANES-1:0]          lane_valid_out,
   output logic [LANES-1:0]          illegal_out,
   output logic [CNT_W-1:0]          illegal_count
);

   // state | meaning
   // EMPTY | no bundle buffered
   // ONE   | head (main) entry holds a bundle
   // TWO   | main and skid both hold bundles; upstream stalled
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state, state_nxt;

   logic [LANES*CTRL_W-1:0] dec_ctrl, main_ctrl, skid_ctrl;
   logic [LANES-1:0]        dec_ill, main_ill, skid_ill, main_lv, skid_lv;
   logic [3:0]              dec_pop;
   logic [CNT_W+3:0]        cnt_sum;
   logic                    accept, emit;

   // {illegal, bundle[9:0]}; a disabled lane decodes to all zeros
   function automatic logic [10:0] decode_lane(input logic [6:0] op, input logic en);
      logic [10:0] r;
      r = 11'd0;
      if (en) begin
         case (op)
            7'b0000011: r = {1'b0, 10'b0_1_00_1_0_1_0_00};
            7'b0100011: r = {1'b0, 10'b0_0_01_1_1_0_0_00};
            7'b0110011: r = {1'b0, 10'b0_1_00_0_0_0_0_10};
            7'b0010011: r = {1'b0, 10'b0_1_00_1_0_0_0_00};
            7'b1100011: r = {1'b0, 10'b0_0_10_0_0_0_1_01};
`ifdef DECODE_JUMP_EN
            7'b1101111: r = {1'b0, 10'b1_1_11_0_0_0_0_00};
`endif
            default:    r = {1'b1, 10'b0};
         endcase
      end
      return r;
   endfunction

   always_comb begin
      logic [10:0] d;
      dec_ctrl = '0;
      dec_ill  = '0;
      dec_pop  = 4'd0;
      d        = 11'd0;
      for (int i = 0; i < LANES; i++) begin
         d = decode_lane(op_in[7*i +: 7], lane_en[i]);
         dec_ctrl[CTRL_W*i +: CTRL_W] = d[CTRL_W-1:0];
         dec_ill[i] = d[10];
         dec_pop    = dec_pop + {3'b000, d[10]};
      end
   end

   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;
   assign out_valid = (state != S_EMPTY);

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (accept) state_nxt = S_ONE;
            S_ONE: begin
               if (accept && !emit)      state_nxt = S_TWO;
               else if (emit && !accept) state_nxt = S_EMPTY;
            end
            S_TWO:   if (emit) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   // Main is the head; skid only fills when the head is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_EMPTY;
         in_ready  <= 1'b1;
         main_ctrl <= '0;
         main_ill  <= '0;
         main_lv   <= '0;
         skid_ctrl <= '0;
         skid_ill  <= '0;
         skid_lv   <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != S_TWO);
         if (!flush) begin
            case (state)
               S_EMPTY: begin
                  if (accept) begin
                     main_ctrl <= dec_ctrl;
                     main_ill  <= dec_ill;
                     main_lv   <= lane_en;
                  end
               end
               S_ONE: begin
                  if (accept && !emit) begin
                     skid_ctrl <= dec_ctrl;
                     skid_ill  <= dec_ill;
                     skid_lv   <= lane_en;
                  end else if (accept && emit) begin
                     main_ctrl <= dec_ctrl;
                     main_ill  <= dec_ill;
                     main_lv   <= lane_en;
                  end
               end
               S_TWO: begin
                  if (emit) begin
                     main_ctrl <= skid_ctrl;
                     main_ill  <= skid_ill;
                     main_lv   <= skid_lv;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ctrl_out       = main_ctrl;
   assign illegal_out    = main_ill;
   assign lane_valid_out = main_lv;

   assign cnt_sum = {4'b0000, illegal_count} + {{CNT_W{1'b0}}, dec_pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_count <= '0;
      end else if (accept && !flush) begin
         if (cnt_sum > {4'b0000, CNT_MAX}) illegal_count <= CNT_MAX;
         else                              illegal_count <= cnt_sum[CNT_W-1:0];
      end
   end

endmodule

// File: doc/multi_lane_decode_stage.md
Name: multi_lane_decode_stage

Overview:
- Parametrised N-lane main-decode stage for the multi-PE RISC-V pipeline.
- Decodes one 7-bit opcode per lane into a packed control bundle, flags illegal opcodes, and registers the results into the ID/EX boundary.
- Upstream and downstream use valid/ready handshakes; a 2-entry elastic buffer gives full throughput with a registered in_ready.
- Supports pipeline flush and keeps a saturating illegal-opcode counter.

Parameters:
- LANES, 2, number of parallel decode lanes (PEs), 1..8
- CNT_W, 16, width of the illegal-opcode counter
- CTRL_W, 10, control bundle width per lane (fixed at 10; exposed for port sizing only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept; registered
- op_in  in  LANES*7  opcodes; lane i = op_in[7*i+6:7*i]
- lane_en  in  LANES  per-lane instruction present
- flush  in  1  discard all buffered and incoming bundles
- out_valid  out  1  ctrl_out holds a valid bundle
- out_ready  in  1  downstream accepts
- ctrl_out  out  LANES*CTRL_W  lane i = [10*i+9:10*i]
- lane_valid_out  out  LANES  per-lane valid of head bundle
- illegal_out  out  LANES  per-lane illegal-opcode flag of head bundle
- illegal_count  out  CNT_W  saturating count of accepted illegal lanes

Behaviour:
- Bundle bit order: [9]Jump [8]RegWrite [7:6]ImmSrc [5]ALUSrc [4]MemWrite [3]ResultSrc [2]Branch [1:0]ALUOp.
- Decode table (combinational, per lane):
  - 0000011 load: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=00, ALUOp=00
  - 0100011 store: MemWrite=1, ALUSrc=1, ImmSrc=01, ALUOp=00
  - 0110011 R-type: RegWrite=1, ALUOp=10
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ALUOp=00
  - 1100011 branch: Branch=1, ImmSrc=10, ALUOp=01
  - All other fields are 0.
- Any other opcode with lane_en=1: bundle=0, illegal=1.
- lane_en=0: bundle=0, illegal=0, lane_valid=0, regardless of opcode.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - Data captured at accept; output latency is 1 cycle from accept to out_valid.
- Buffer FSM, entries main (head) and skid:
  - EMPTY: accept -> ONE.
  - ONE: accept && !emit -> TWO (new data to skid). emit && !accept -> EMPTY. accept && emit -> ONE (new data to main).
  - TWO: emit -> ONE (skid moves to main). No accept possible.
- in_ready = (state != TWO), registered from next state.
- out_valid = (state != EMPTY).
- Outputs are stable while out_valid && !out_ready.
- Flush: next state EMPTY; the input that cycle is dropped, not counted, and in_ready is 1 next cycle. Flush has priority over accept and emit.
- illegal_count:
  - On accept without flush, adds popcount(illegal lanes of the incoming bundle).
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush.
- Reset (async, any time including mid-transfer):
  - State EMPTY; out_valid=0; in_ready=1.
  - ctrl_out, lane_valid_out, illegal_out all 0; illegal_count=0.

Optional Feature:
- Macro DECODE_JUMP_EN.
- Defined: opcode 1101111 (JAL) is legal and decodes to Jump=1, RegWrite=1, ImmSrc=11, other fields 0.
- Undefined: 1101111 is illegal, bundle=0, and bit 9 is constant 0.

Test Plan:
- Reset released, LANES=2, op_in={0110011,0000011}, lane_en=11, in_valid=1, out_ready=1 -> next cycle out_valid=1, lane0 ctrl=10'b0_1_00_1_0_1_0_00, lane1 ctrl=10'b0_1_00_0_0_0_0_10, illegal_out=00.
- out_ready=0, three back-to-back bundles -> first two accepted, in_ready=0 after the second, the third is held upstream. Set out_ready=1 -> the three bundles emerge in order, one per cycle, no bubbles.
- op_in lane1=1111111, lane_en=11, then lane_en=01 with the same opcode -> the first transfer gives illegal_out=10 and illegal_count=1; the second gives illegal_out=00, lane_valid_out=01, and the count stays 1.
- State TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_count unchanged, and no flushed bundle ever appears.
- CNT_W=2, accept 5 bundles with 1 illegal lane each -> illegal_count reads 1,2,3,3,3.
- Assert rst asynchronously mid-cycle in state ONE -> out_valid and all outputs are 0 immediately, without waiting for a clock edge. With DECODE_JUMP_EN, opcode 1101111 gives ctrl=10'b1_1_11_0_0_0_0_00 and illegal_out=0.
